// File: rtl/timer_pkg.sv
// Shared timer definitions: register map, legal address limit, APB FSM encoding.
package timer_pkg;

    localparam logic [11:0] TCR   = 12'h000;
    localparam logic [11:0] TDR0  = 12'h004;
    localparam logic [11:0] TDR1  = 12'h008;
    localparam logic [11:0] TCMP0 = 12'h00C;
    localparam logic [11:0] TCMP1 = 12'h010;
    localparam logic [11:0] TIER  = 12'h014;
    localparam logic [11:0] TISR  = 12'h018;
    localparam logic [11:0] THCSR = 12'h01C;

    localparam logic [11:0] MAX_ADDR = THCSR;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_state_e;

endpackage

// File: rtl/timer_apb_ctrl.sv
// APB slave front-end and access sequencer for the timer register file.
// Define TIMER_APB_PSLVERR_EN to enable misaligned/out-of-range error responses.
module timer_apb_ctrl
    import timer_pkg::*;
#(
    parameter int                WAIT_CYCLES = 0,
    parameter int                ADDR_W      = 12,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] MAX_ADDR    = ADDR_W'(timer_pkg::MAX_ADDR)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    input  logic [3:0]        pstrb,
    output logic              pready,
    output logic [DATA_W-1:0] prdata,
    output logic              pslverr,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic [3:0]        reg_pstrb,
    input  logic [DATA_W-1:0] reg_rdata
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    apb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        strb_q, strb_d;
    logic              write_q, write_d;
    logic              err_q, err_d;
    logic              addr_err;

`ifdef TIMER_APB_PSLVERR_EN
    assign addr_err = (paddr[1:0] != 2'b00) || (paddr > MAX_ADDR);
`else
    assign addr_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            write_q <= write_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        write_d   = write_q;
        err_d     = err_q;
        pready    = 1'b0;
        pslverr   = 1'b0;
        reg_wr_en = 1'b0;
        reg_rd_en = 1'b0;
        prdata    = '0;

        unique case (state_q)
            IDLE: begin
                // Only a clean setup phase starts a transfer.
                if (psel && !penable) begin
                    addr_d  = paddr;
                    wdata_d = pwdata;
                    strb_d  = pwrite ? pstrb : 4'b0000;
                    write_d = pwrite;
                    err_d   = addr_err;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                if (psel) begin
                    pready    = 1'b1;
                    pslverr   = err_q;
                    reg_wr_en = write_q & ~err_q;
                    reg_rd_en = ~write_q & ~err_q;
                    prdata    = (~write_q & ~err_q) ? reg_rdata : '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_pstrb = strb_q;

endmodule

// File: tb/tb_timer_apb_ctrl.sv
// Bench for timer_apb_ctrl: zero-wait and three-wait instances against a
// transfer-level model with per-cycle expected responses.
module tb_timer_apb_ctrl;

    localparam int NCYC = 2048;
    localparam int W1   = 3;

    typedef struct packed {
        bit        rdy;
        bit        wr;
        bit        rd;
        bit        err;
        bit [31:0] rdata;
        bit [11:0] addr;
        bit [31:0] wdata;
        bit [3:0]  strb;
    } exp_t;

    logic        clk;
    logic        rst_n_s   [2];
    logic        psel_s    [2];
    logic        penable_s [2];
    logic        pwrite_s  [2];
    logic [11:0] paddr_s   [2];
    logic [31:0] pwdata_s  [2];
    logic [3:0]  pstrb_s   [2];
    logic        pready_s  [2];
    logic [31:0] prdata_s  [2];
    logic        pslverr_s [2];
    logic        wr_en_s   [2];
    logic        rd_en_s   [2];
    logic [11:0] raddr_s   [2];
    logic [31:0] rwdata_s  [2];
    logic [3:0]  rstrb_s   [2];
    logic [31:0] rrdata_s  [2];

    logic [31:0] rf  [2][8];
    logic [31:0] mdl [2][8];
    exp_t        exp_tab [2][NCYC];
    exp_t        cx;

    int cyc;
    int nvec;
    int nfail;
    int last_rdy_cyc [2];
    logic [31:0] last_prdata [2];
    logic last_err [2];
    logic last_wr  [2];
    int rdy_cnt [2];

    timer_apb_ctrl #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n_s[0]),
        .psel(psel_s[0]), .penable(penable_s[0]), .pwrite(pwrite_s[0]),
        .paddr(paddr_s[0]), .pwdata(pwdata_s[0]), .pstrb(pstrb_s[0]),
        .pready(pready_s[0]), .prdata(prdata_s[0]), .pslverr(pslverr_s[0]),
        .reg_wr_en(wr_en_s[0]), .reg_rd_en(rd_en_s[0]),
        .reg_addr(raddr_s[0]), .reg_wdata(rwdata_s[0]),
        .reg_pstrb(rstrb_s[0]), .reg_rdata(rrdata_s[0])
    );

    timer_apb_ctrl #(.WAIT_CYCLES(W1)) u_w3 (
        .clk(clk), .rst_n(rst_n_s[1]),
        .psel(psel_s[1]), .penable(penable_s[1]), .pwrite(pwrite_s[1]),
        .paddr(paddr_s[1]), .pwdata(pwdata_s[1]), .pstrb(pstrb_s[1]),
        .pready(pready_s[1]), .prdata(prdata_s[1]), .pslverr(pslverr_s[1]),
        .reg_wr_en(wr_en_s[1]), .reg_rd_en(rd_en_s[1]),
        .reg_addr(raddr_s[1]), .reg_wdata(rwdata_s[1]),
        .reg_pstrb(rstrb_s[1]), .reg_rdata(rrdata_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Simple register file behind each instance.
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            rrdata_s[d] = (raddr_s[d] <= 12'h01C) ? rf[d][raddr_s[d][4:2]] : 32'h0;
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (wr_en_s[d] === 1'b1 && raddr_s[d] <= 12'h01C) begin
                for (int b = 0; b < 4; b++) begin
                    if (rstrb_s[d][b]) rf[d][raddr_s[d][4:2]][8*b +: 8] <= rwdata_s[d][8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string nm, input int d, input logic [31:0] act,
                       input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, d, cyc, act, expv);
        end
    endtask

    function automatic bit exp_err(input logic [11:0] a);
`ifdef TIMER_APB_PSLVERR_EN
        return (a[1:0] != 2'b00) || (a > 12'h01C);
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        if (cyc < NCYC) begin
            for (int d = 0; d < 2; d++) begin
                cx = exp_tab[d][cyc];
                chk("pready", d, {31'b0, pready_s[d]}, {31'b0, cx.rdy});
                chk("pslverr", d, {31'b0, pslverr_s[d]}, {31'b0, cx.err});
                chk("reg_wr_en", d, {31'b0, wr_en_s[d]}, {31'b0, cx.wr});
                chk("reg_rd_en", d, {31'b0, rd_en_s[d]}, {31'b0, cx.rd});
                chk("prdata", d, prdata_s[d], cx.rdata);
                if (cx.wr || cx.rd) begin
                    chk("reg_addr", d, {20'b0, raddr_s[d]}, {20'b0, cx.addr});
                    chk("reg_pstrb", d, {28'b0, rstrb_s[d]}, {28'b0, cx.strb});
                end
                if (cx.wr) chk("reg_wdata", d, rwdata_s[d], cx.wdata);
                if (pready_s[d] === 1'b1) begin
                    last_rdy_cyc[d] = cyc;
                    last_prdata[d]  = prdata_s[d];
                    last_err[d]     = pslverr_s[d];
                    last_wr[d]      = wr_en_s[d];
                    rdy_cnt[d]++;
                end
            end
        end
    end

    // One APB transfer; abort_at=k drops psel in cycle setup+k.
    task automatic xfer(input int d, input bit wr, input logic [11:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        input int abort_at, output int t0);
        int   w;
        bit   e;
        bit   gone;
        exp_t x;
        w    = (d == 0) ? 0 : W1;
        e    = exp_err(a);
        t0   = cyc;
        gone = 1'b0;
        psel_s[d]    = 1'b1;
        penable_s[d] = 1'b0;
        pwrite_s[d]  = wr;
        paddr_s[d]   = a;
        pwdata_s[d]  = wd;
        pstrb_s[d]   = st;
        if (abort_at == 0) begin
            x       = '0;
            x.rdy   = 1'b1;
            x.err   = e;
            x.wr    = wr & ~e;
            x.rd    = ~wr & ~e;
            x.addr  = a;
            x.wdata = wd;
            x.strb  = wr ? st : 4'b0000;
            if (x.rd) x.rdata = (a <= 12'h01C) ? mdl[d][a[4:2]] : 32'h0;
            if (t0 + 1 + w < NCYC) exp_tab[d][t0 + 1 + w] = x;
            if (x.wr && a <= 12'h01C) begin
                for (int b = 0; b < 4; b++) begin
                    if (st[b]) mdl[d][a[4:2]][8*b +: 8] = wd[8*b +: 8];
                end
            end
        end
        for (int k = 1; k <= w + 1; k++) begin
            @(posedge clk);
            #1;
            if (!gone) begin
                penable_s[d] = 1'b1;
                if (k == abort_at) begin
                    psel_s[d]    = 1'b0;
                    penable_s[d] = 1'b0;
                    gone         = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        psel_s[d]    = 1'b0;
        penable_s[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int rc;
        nvec  = 0;
        nfail = 0;
        for (int d = 0; d < 2; d++) begin
            rst_n_s[d]   = 1'b0;
            psel_s[d]    = 1'b0;
            penable_s[d] = 1'b0;
            pwrite_s[d]  = 1'b0;
            paddr_s[d]   = '0;
            pwdata_s[d]  = '0;
            pstrb_s[d]   = '0;
            rdy_cnt[d]   = 0;
            last_rdy_cyc[d] = 0;
            last_prdata[d]  = '0;
            last_err[d]  = 1'b0;
            last_wr[d]   = 1'b0;
            for (int i = 0; i < 8; i++) begin
                rf[d][i]  = 32'h0;
                mdl[d][i] = 32'h0;
            end
            rf[d][0]  = 32'h0000_0100;
            mdl[d][0] = 32'h0000_0100;
        end

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_reg_addr", d, {20'b0, raddr_s[d]}, 32'h0);
            chk("rst_reg_wdata", d, rwdata_s[d], 32'h0);
            chk("rst_reg_pstrb", d, {28'b0, rstrb_s[d]}, 32'h0);
        end
        rst_n_s[0] = 1'b1;
        rst_n_s[1] = 1'b1;
        @(posedge clk);
        #1;

        // Zero-wait instance
        xfer(0, 1'b1, 12'h00C, 32'h0000_1234, 4'hF, 0, t);
        chk("w0_wr_latency", 0, last_rdy_cyc[0] - t, 32'd1);
        chk("w0_wr_strobe", 0, {31'b0, last_wr[0]}, 32'd1);
        xfer(0, 1'b0, 12'h00C, 32'h0, 4'hF, 0, t);
        chk("w0_tcmp0_read", 0, last_prdata[0], 32'h0000_1234);
        xfer(0, 1'b1, 12'h010, 32'hAABB_CCDD, 4'b0101, 0, t);
        xfer(0, 1'b0, 12'h010, 32'h0, 4'hF, 0, t);
        chk("w0_partial_strb", 0, last_prdata[0], 32'h00BB_00DD);
        xfer(0, 1'b1, 12'h00C, 32'hFFFF_FFFF, 4'b0000, 0, t);
        xfer(0, 1'b0, 12'h00C, 32'h0, 4'hF, 0, t);
        chk("w0_zero_strb", 0, last_prdata[0], 32'h0000_1234);

        rc = rdy_cnt[0];
        psel_s[0]    = 1'b1;
        penable_s[0] = 1'b1;
        paddr_s[0]   = 12'h00C;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        psel_s[0]    = 1'b0;
        penable_s[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("w0_proto_violation", 0, rdy_cnt[0] - rc, 32'd0);

        xfer(0, 1'b1, 12'h004, 32'hAAAA_5555, 4'hF, 0, t);
        xfer(0, 1'b0, 12'h004, 32'h0, 4'hF, 0, t);
        chk("w0_b2b_read", 0, last_prdata[0], 32'hAAAA_5555);
        xfer(0, 1'b1, 12'h01C, 32'h0000_00C3, 4'hF, 0, t);
        xfer(0, 1'b0, 12'h01C, 32'h0, 4'hF, 0, t);
        chk("w0_max_addr", 0, last_prdata[0], 32'h0000_00C3);
        xfer(0, 1'b1, 12'h020, 32'h1111_1111, 4'hF, 0, t);
        xfer(0, 1'b0, 12'h020, 32'h0, 4'hF, 0, t);
        chk("w0_oob_rdata", 0, last_prdata[0], 32'h0);
`ifdef TIMER_APB_PSLVERR_EN
        chk("w0_oob_err", 0, {31'b0, last_err[0]}, 32'd1);
`else
        chk("w0_oob_err", 0, {31'b0, last_err[0]}, 32'd0);
`endif
        xfer(0, 1'b0, 12'h006, 32'h0, 4'hF, 0, t);
`ifdef TIMER_APB_PSLVERR_EN
        chk("w0_misalign", 0, last_prdata[0], 32'h0);
`else
        chk("w0_misalign", 0, last_prdata[0], 32'hAAAA_5555);
`endif

        // Three-wait instance
        xfer(1, 1'b0, 12'h000, 32'h0, 4'hF, 0, t);
        chk("w3_rd_latency", 1, last_rdy_cyc[1] - t, 32'd4);
        chk("w3_tcr_read", 1, last_prdata[1], 32'h0000_0100);
        rc = rdy_cnt[1];
        xfer(1, 1'b1, 12'h014, 32'h0000_0005, 4'hF, 2, t);
        chk("w3_wait_abort", 1, rdy_cnt[1] - rc, 32'd0);
        xfer(1, 1'b1, 12'h014, 32'h0000_0001, 4'hF, 0, t);
        xfer(1, 1'b0, 12'h014, 32'h0, 4'hF, 0, t);
        chk("w3_tier_read", 1, last_prdata[1], 32'h0000_0001);
        xfer(1, 1'b1, 12'h008, 32'h0000_0077, 4'hF, W1 + 1, t);
        xfer(1, 1'b0, 12'h008, 32'h0, 4'hF, 0, t);
        chk("w3_resp_abort", 1, last_prdata[1], 32'h0);

        psel_s[1]    = 1'b1;
        penable_s[1] = 1'b0;
        pwrite_s[1]  = 1'b1;
        paddr_s[1]   = 12'h018;
        pwdata_s[1]  = 32'h0000_DEAD;
        pstrb_s[1]   = 4'hF;
        @(posedge clk);
        #1;
        penable_s[1] = 1'b1;
        repeat (W1) begin
            @(posedge clk);
            #1;
        end
        chk("rst_pre_rdy", 1, {31'b0, pready_s[1]}, 32'd1);
        #1;
        rst_n_s[1] = 1'b0;
        #1;
        chk("rst_rdy_drop", 1, {31'b0, pready_s[1]}, 32'd0);
        chk("rst_wr_drop", 1, {31'b0, wr_en_s[1]}, 32'd0);
        chk("rst_addr_clr", 1, {20'b0, raddr_s[1]}, 32'h0);
        @(posedge clk);
        #1;
        psel_s[1]    = 1'b0;
        penable_s[1] = 1'b0;
        @(posedge clk);
        #1;
        rst_n_s[1] = 1'b1;
        chk("rst_rdy_stay", 1, {31'b0, pready_s[1]}, 32'd0);
        xfer(1, 1'b0, 12'h018, 32'h0, 4'hF, 0, t);
        chk("post_rst_read", 1, last_prdata[1], 32'h0);
        chk("post_rst_latency", 1, last_rdy_cyc[1] - t, 32'd4);
        xfer(1, 1'b1, 12'h01C, 32'h0000_5A5A, 4'hF, 0, t);
        xfer(1, 1'b0, 12'h01C, 32'h0, 4'hF, 0, t);
        chk("post_rst_wr_rd", 1, last_prdata[1], 32'h0000_5A5A);

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
